afifo_rd_burst_packer: RTL and testbench
========================================

// Module: afifo_rd_burst_packer
// PURPOSE
//  Read-side consumer of the async FIFO, clocked by rd_clk. Pops 32-bit words, packs them into
//  bursts of BURST_LEN data beats, and appends one checksum trailer beat (m_last=1) per burst.
//  Output is a valid/ready stream. A 4-entry output queue absorbs downstream backpressure.
//  Partial bursts are flushed with a trailer after the FIFO stays empty for FLUSH_TIMEOUT cycles.
// PARAMETERS
//  DATA_W         32   word width; equals FIFO data_out width
//  BURST_LEN      8    data beats per full burst (>=1)
//  FLUSH_TIMEOUT  64   consecutive empty cycles with a partial burst before a forced trailer (>=1)
//  OQ_DEPTH       4    output queue entries; power of 2, >=2
// PORTS
//  rd_clk       in   1       FIFO read clock; the only clock
//  reset        in   1       synchronous, active-high
//  fifo_empty   in   1       FIFO empty flag
//  data_out     in   DATA_W  FIFO read data; valid 1 cycle after rd_en is sampled high
//  rd_en        out  1       FIFO pop request
//  m_valid      out  1       output beat valid
//  m_ready      in   1       downstream accept
//  m_data       out  DATA_W  data beat or checksum trailer
//  m_last       out  1       1 = trailer beat, which closes the burst
//  burst_count  out  16      number of trailers emitted; wraps at 2^16
// BEHAVIOUR
//  - Reset values: all outputs 0. Queue, counters, sum, in-flight flag and FSM are cleared.
//    State returns to READ. A data_out returning after reset is discarded.
//  - Clock and reset: single clock rd_clk. Reset is synchronous, active-high, and named reset.
//  - Pop rule (rd_en is registered-free combinational):
//    rd_en = state==READ && !fifo_empty && issued<BURST_LEN && (oq_count+inflight)<OQ_DEPTH.
//    inflight is set on the cycle after rd_en=1. On that cycle data_out is pushed into the queue,
//    added to sum, and rcvd is incremented. At most one read is outstanding.
//  - sum is DATA_W wide and wraps modulo 2^DATA_W. The trailer beat carries m_data=sum.
//  - FSM:
//    READ -> TRAIL when rcvd==BURST_LEN after a push.
//    READ -> TRAIL when rcvd>0 && inflight==0 && empty_timer==FLUSH_TIMEOUT.
//    TRAIL: rd_en=0. When oq_count<OQ_DEPTH and inflight==0, push {last=1,sum}.
//           Then clear sum/issued/rcvd/empty_timer, increment burst_count, and go to READ.
//  - empty_timer counts consecutive cycles with fifo_empty=1 in READ and saturates at
//    FLUSH_TIMEOUT. It clears whenever fifo_empty=0 or a pop occurs.
//  - Zero-word bursts never produce a trailer. With rcvd==0 the timeout is ignored.
//  - Output: m_valid = oq_count>0; m_data/m_last come from the queue head.
//    A beat transfers when m_valid && m_ready. Push and pop in the same cycle keep oq_count unchanged.
//  - Hold rule: m_data/m_last stay stable while m_valid && !m_ready.
//  - Queue-full invariant: the queue never overflows. A push is only allowed when a slot was
//    reserved via the oq_count+inflight check.
//  - Words are delivered in FIFO order with none lost or duplicated, under any m_ready pattern.
//  - Latency: fifo word visible on m_data 2 cycles after rd_en=1 when the queue is empty and
//    m_ready=1.
// STRUCTURE
//  - afifo_pkg: DATA_W default, burst_state_e {READ, TRAIL}, and a typedef for oq entry
//    struct {logic last; logic [DATA_W-1:0] data;}.
//  - Sub-module afifo_rd_oq: synchronous OQ_DEPTH-entry queue with push/pop/count.
//    It uses the same rd_clk and reset.
//  - The top level holds the FSM, counters (issued, rcvd, empty_timer, burst_count), sum and
//    the inflight flag.
// TESTING
//  1. Preload FIFO with 1..8, m_ready=1.
//     -> beats 1..8 with m_last=0, then 0x24 with m_last=1; burst_count=1.
//  2. 16 words queued, m_ready=0 for 20 cycles mid-burst.
//     -> rd_en drops once oq_count+inflight=4. After release, all words arrive in order with
//        no loss or duplicate.
//  3. FLUSH_TIMEOUT=16, push 0xA,0xB,0xC, then FIFO stays empty.
//     -> trailer 0x21 with m_last=1 follows 16 empty cycles; burst_count=1.
//  4. fifo_empty held 1 for 200 cycles after reset.
//     -> rd_en never 1, m_valid never 1, burst_count=0.
//  5. Reset pulsed for 1 cycle after 5 words of a burst, including one in flight.
//     -> all outputs 0 the next cycle. The next 8 words 1..8 give trailer 0x24.
//  6. Eight words of 0xFFFFFFFF.
//     -> trailer 0xFFFFFFF8 (modulo 2^32 wrap).

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared types for the async-FIFO read-side burst packer: FSM states and output queue entry.
package afifo_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        READ  = 1'b0,
        TRAIL = 1'b1
    } burst_state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } oq_entry_t;

endpackage

// File: rtl/afifo_rd_burst_packer_if.sv
// FIFO read port plus valid/ready output stream of the burst packer.
interface afifo_rd_burst_packer_if
    import afifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              fifo_empty;
    logic [DATA_W-1:0] data_out;
    logic              rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  fifo_empty, data_out, m_ready,
        output rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, data_out, m_ready,
        input  rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/afifo_rd_oq.sv
// Small synchronous circular queue with push/pop/count; DEPTH must be a power of 2.
module afifo_rd_oq
    import afifo_pkg::*;
#(
    parameter type entry_t = oq_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                     rd_clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/afifo_rd_burst_packer.sv
// Pops FIFO words into bursts of BURST_LEN beats, each closed by a checksum trailer (m_last=1);
// partial bursts are flushed after FLUSH_TIMEOUT empty cycles.
module afifo_rd_burst_packer
    import afifo_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int BURST_LEN     = 8,
    parameter int FLUSH_TIMEOUT = 64,
    parameter int OQ_DEPTH      = 4
) (
    input  logic                    rd_clk,
    input  logic                    reset,
    afifo_rd_burst_packer_if.master bus,
    output logic [15:0]             burst_count
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam int QW = $clog2(OQ_DEPTH) + 1;

    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [TW-1:0] TIMEOUT_C   = TW'(FLUSH_TIMEOUT);
    localparam logic [QW:0]   DEPTH_C     = (QW+1)'(OQ_DEPTH);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } oq_ent_t;

    burst_state_e      state;
    burst_state_e      state_nxt;
    logic [CW-1:0]     issued;
    logic [CW-1:0]     rcvd;
    logic [TW-1:0]     empty_timer;
    logic [DATA_W-1:0] sum;
    logic              inflight;
    logic              rd_en_c;
    logic              trail_push;
    logic              oq_push;
    logic              oq_pop;
    logic [QW-1:0]     oq_count;
    logic [QW:0]       occupancy;
    oq_ent_t           oq_wdata;
    oq_ent_t           oq_head;

    afifo_rd_oq #(
        .entry_t (oq_ent_t),
        .DEPTH   (OQ_DEPTH)
    ) u_oq (
        .rd_clk     (rd_clk),
        .reset      (reset),
        .push       (oq_push),
        .push_entry (oq_wdata),
        .pop        (oq_pop),
        .head       (oq_head),
        .count      (oq_count)
    );

    // A read is only issued when a queue slot is free for its returning word.
    always_comb begin
        occupancy  = {1'b0, oq_count} + (QW+1)'(inflight);
        rd_en_c    = !reset && (state == READ) && !bus.fifo_empty &&
                     (issued < BURST_LEN_C) && (occupancy < DEPTH_C);
        trail_push = (state == TRAIL) && !inflight && ({1'b0, oq_count} < DEPTH_C);
        oq_push    = inflight || trail_push;
        oq_wdata   = {trail_push, (trail_push ? sum : bus.data_out)};
        oq_pop     = bus.m_valid && bus.m_ready;

        state_nxt = state;
        unique case (state)
            READ: begin
                if (inflight && (rcvd + CW'(1) == BURST_LEN_C)) begin
                    state_nxt = TRAIL;
                end else if ((rcvd != '0) && !inflight && (empty_timer == TIMEOUT_C)) begin
                    state_nxt = TRAIL;
                end
            end
            TRAIL: begin
                if (trail_push) begin
                    state_nxt = READ;
                end
            end
            default: state_nxt = READ;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state <= READ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            issued      <= '0;
            rcvd        <= '0;
            empty_timer <= '0;
            sum         <= '0;
            inflight    <= 1'b0;
            burst_count <= '0;
        end else begin
            inflight <= rd_en_c;
            if (trail_push) begin
                issued      <= '0;
                rcvd        <= '0;
                sum         <= '0;
                burst_count <= burst_count + 16'd1;
            end else begin
                if (rd_en_c) begin
                    issued <= issued + CW'(1);
                end
                if (inflight) begin
                    rcvd <= rcvd + CW'(1);
                    sum  <= sum + bus.data_out;
                end
            end
            if ((state != READ) || !bus.fifo_empty) begin
                empty_timer <= '0;
            end else if (empty_timer != TIMEOUT_C) begin
                empty_timer <= empty_timer + TW'(1);
            end
        end
    end

    // Head is masked when empty so stale queue contents never reach the outputs.
    assign bus.rd_en   = rd_en_c;
    assign bus.m_valid = (oq_count != '0);
    assign bus.m_data  = bus.m_valid ? oq_head.data : '0;
    assign bus.m_last  = bus.m_valid && oq_head.last;

endmodule

// File: tb/tb_afifo_rd_burst_packer.sv
// Self-checking bench: FIFO model plus stream scoreboard (order, burst length, trailer sums).
module tb_afifo_rd_burst_packer;
    localparam int BL  = 8;
    localparam int FT  = 16;
    localparam int OQD = 4;

    logic        rd_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] burst_count;

    afifo_rd_burst_packer_if #(.DATA_W(32)) bus ();

    afifo_rd_burst_packer #(
        .DATA_W        (32),
        .BURST_LEN     (BL),
        .FLUSH_TIMEOUT (FT),
        .OQ_DEPTH      (OQD)
    ) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .bus         (bus),
        .burst_count (burst_count)
    );

    always #5 rd_clk = ~rd_clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          trailers = 0;
    int          sb_cnt = 0;
    int          last_len = 0;
    int          ready_mode = 1;
    int          lat_rd = -1;
    int          lat_v = -1;
    int          vcnt = 0;
    int          ecnt = 0;
    int          quiet = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] sb_sum = '0;
    logic [31:0] last_trailer = '0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    bit          s_rd_en, s_m_valid, s_empty, s_trailer;
    bit          hold_pend = 1'b0;
    bit          post_reset_chk = 1'b0;
    bit          lat_arm = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic consume();
        logic [31:0] w;
        if (bus.m_last) begin
            chk("trailer_after_words", 32'(sb_cnt != 0), 32'd1);
            chk("trailer_sum", bus.m_data, sb_sum);
            last_trailer = bus.m_data;
            last_len     = sb_cnt;
            trailers++;
            sb_sum = '0;
            sb_cnt = 0;
        end else begin
            chk("burst_not_overlong", 32'(sb_cnt < BL), 32'd1);
            chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("data_order", bus.m_data, w);
                sb_sum = sb_sum + w;
                sb_cnt++;
            end
        end
    endtask

    // One clock: observe at negedge, then model the FIFO and drive inputs just after posedge.
    task automatic tick();
        @(negedge rd_clk);
        cyc++;
        s_rd_en   = bus.rd_en;
        s_m_valid = bus.m_valid;
        s_empty   = bus.fifo_empty;
        s_trailer = bus.m_valid && bus.m_last;
        if (post_reset_chk) begin
            chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
            chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
            chk("rst_m_data", bus.m_data, 32'd0);
            chk("rst_m_last", 32'(bus.m_last), 32'd0);
            chk("rst_burst_count", 32'(burst_count), 32'd0);
        end
        if (lat_arm) begin
            if (s_rd_en && lat_rd < 0) lat_rd = cyc;
            if (s_m_valid && lat_v < 0) lat_v = cyc;
        end
        if (!reset) begin
            if (bus.rd_en) begin
                rd_cnt++;
                chk("rd_en_when_empty", 32'(bus.fifo_empty), 32'd0);
            end
            if (hold_pend) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", bus.m_data, hold_data);
                chk("hold_last", 32'(bus.m_last), 32'(hold_last));
            end
            hold_pend = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
            hold_last = bus.m_last;
            if (bus.m_valid && bus.m_ready) consume();
        end else begin
            hold_pend = 1'b0;
        end
        @(posedge rd_clk);
        #1;
        if (s_rd_en && fifo_q.size() != 0) bus.data_out = fifo_q.pop_front();
        else bus.data_out = $urandom;
        bus.fifo_empty = (fifo_q.size() == 0);
        case (ready_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = ($urandom_range(0, 99) < 70);
        endcase
    endtask

    task automatic wait_trailers(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && trailers < n; i++) tick();
        chk(tag, 32'(trailers), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        sb_sum   = '0;
        sb_cnt   = 0;
        trailers = 0;
        bus.fifo_empty = 1'b1;
        tick();
        reset = 1'b0;
        post_reset_chk = 1'b1;
        tick();
        post_reset_chk = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.data_out   = '0;
        bus.m_ready    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        post_reset_chk = 1'b1;
        tick();
        post_reset_chk = 1'b0;

        // Idle with an empty FIFO: nothing may be read or emitted.
        rd_cnt = 0;
        vcnt = 0;
        repeat (200) begin
            tick();
            if (s_m_valid) vcnt++;
        end
        chk("idle_rd_en", 32'(rd_cnt), 32'd0);
        chk("idle_m_valid", 32'(vcnt), 32'd0);
        chk("idle_burst_count", 32'(burst_count), 32'd0);

        // Full burst 1..8.
        lat_rd = -1;
        lat_v = -1;
        lat_arm = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        wait_trailers("t1_trailer_seen", 1, 100);
        lat_arm = 1'b0;
        chk("t1_latency", 32'(lat_v - lat_rd), 32'd2);
        chk("t1_trailer", last_trailer, 32'h24);
        chk("t1_len", 32'(last_len), 32'd8);
        chk("t1_burst_count", 32'(burst_count), 32'd1);

        // Backpressure: only OQ_DEPTH reads may be outstanding while stalled.
        repeat (4) tick();
        ready_mode = 0;
        bus.m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 16; i++) push_word($urandom);
        repeat (20) tick();
        chk("t2_reads_while_stalled", 32'(rd_cnt), 32'(OQD));
        ready_mode = 1;
        bus.m_ready = 1'b1;
        wait_trailers("t2_two_bursts", 3, 300);
        chk("t2_all_words", 32'(exp_q.size()), 32'd0);
        chk("t2_burst_count", 32'(burst_count), 32'd3);

        // Partial burst flushed by timeout.
        repeat (30) tick();
        ecnt = 0;
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_trailer) break;
            if (s_empty) ecnt++;
        end
        chk("t3_flush_delay", 32'(ecnt), 32'(FT + 2));
        wait_trailers("t3_trailer_seen", 4, 20);
        chk("t3_trailer", last_trailer, 32'h21);
        chk("t3_len", 32'(last_len), 32'd3);
        chk("t3_burst_count", 32'(burst_count), 32'd4);

        // Sum wrap.
        for (int i = 0; i < 8; i++) push_word(32'hFFFF_FFFF);
        wait_trailers("t6_trailer_seen", 5, 100);
        chk("t6_trailer", last_trailer, 32'hFFFF_FFF8);
        chk("t6_burst_count", 32'(burst_count), 32'd5);

        // Reset mid-burst with a word in flight.
        repeat (5) tick();
        rd_cnt = 0;
        for (int i = 1; i <= 10; i++) push_word(32'(100 + i));
        for (int i = 0; i < 50 && rd_cnt < 5; i++) tick();
        chk("t5_five_reads", 32'(rd_cnt), 32'd5);
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        wait_trailers("t5_trailer_seen", 1, 100);
        chk("t5_trailer", last_trailer, 32'h24);
        chk("t5_burst_count", 32'(burst_count), 32'd1);

        // Random traffic and random backpressure with idle gaps that trigger flushes.
        ready_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 299) == 0) quiet = $urandom_range(5, 40);
            else if ($urandom_range(0, 99) < 35)
                push_word(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
            tick();
        end
        ready_mode = 1;
        for (int i = 0; i < 400 && !(exp_q.size() == 0 && sb_cnt == 0); i++) tick();
        repeat (3) tick();
        chk("rand_fifo_drained", 32'(fifo_q.size()), 32'd0);
        chk("rand_words_delivered", 32'(exp_q.size()), 32'd0);
        chk("rand_burst_closed", 32'(sb_cnt), 32'd0);
        chk("rand_burst_count", 32'(burst_count), 32'(trailers[15:0]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
